instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Opcode producer feeding the control-unit decoder. Holds the PC and fetches words from a
//  synchronous instruction memory. Buffers fetched words and delivers {pc, instr} downstream
//  over a valid/ready handshake. Flushes and re-steers on a branch redirect and stops fetching
//  on HALT. Sits between instruction memory and decode; opcode_out drives the decoder opcode input.
// PARAMETERS
//  PC_W     8        PC / imem address width; PC wraps modulo 2**PC_W
//  INSTR_W  16       instruction width; opcode = instr[INSTR_W-1 -: 5]
//  RESET_PC 0        PC loaded on reset
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        synchronous reset, active low
//  imem_req     out  1        fetch request this cycle
//  imem_addr    out  PC_W     fetch address (valid when imem_req)
//  imem_rdata   in   INSTR_W  read data, valid the cycle after imem_req
//  instr_valid  out  1        instr_out/pc_out/opcode_out valid
//  instr_ready  in   1        downstream accepts this cycle
//  instr_out    out  INSTR_W  instruction word
//  opcode_out   out  5        instr_out[INSTR_W-1 -: 5]
//  pc_out       out  PC_W     address of instr_out
//  redirect     in   1        branch taken: flush and re-steer
//  redirect_pc  in   PC_W     new fetch PC
//  halted       out  1        fetch stopped by HALT
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_PC, state=S_IDLE, buffer empty, inflight=0.
//    imem_req=0, instr_valid=0, instr_out=0, pc_out=0, halted=0.
//    Reset mid-operation discards everything, including in-flight reads.
//  - FSM: S_IDLE -> S_RUN (unconditional, 1 cycle).
//    S_RUN -> S_HALT when a HALT word (opcode 5'h1F) is captured.
//    S_HALT -> S_RUN only on redirect.
//  - Buffer: FIFO of DEPTH entries {pc, instr}. instr_valid = !empty; outputs show the head entry.
//    Transfer = instr_valid & instr_ready pops the head.
//  - Issue (S_RUN, no redirect): imem_req=1 iff (count - pop + inflight) < DEPTH.
//    On issue: imem_addr=pc, then pc<=pc+1 (mod 2**PC_W), inflight<=1 with tag pc.
//    Otherwise imem_req=0 and pc holds.
//  - Capture: the cycle after an issue, imem_rdata+tag is pushed. It is visible on the outputs
//    next cycle. Latency from issue to instr_valid = 2 cycles. First instr_valid is the
//    3rd cycle after rst_n rises.
//  - HALT capture: the HALT word is pushed and delivered normally.
//    state=S_HALT, halted=1, imem_req=0; a concurrent issue/inflight read is discarded.
//    Buffer continues draining.
//  - Redirect (priority over all else):
//    * A simultaneous transfer still counts as accepted.
//    * All other buffer entries are flushed and any inflight read is discarded.
//    * pc<=redirect_pc; imem_req=0 that cycle; state=S_RUN; halted=0.
//    * Fetch resumes at redirect_pc next cycle.
//  - No pushes are lost: issue is credit-gated, so push never occurs while full.
//    Outputs are stable while instr_valid & !instr_ready.
// CONFIGURATION
//  IFU_SKID_BUF_EN defined:
//   - DEPTH=2; sustains 1 instr/cycle with instr_ready=1.
//   - Fetch continues under backpressure until the buffer is full.
//  IFU_SKID_BUF_EN undefined:
//   - DEPTH=1; issue waits for the slot and no inflight read.
//   - Max throughput 1 instr / 2 cycles.
//  All other behaviour is identical.
// TESTING
//  1 imem[0..3] opcodes 2,6,0,1; ready=1 -> opcode_out 2,6,0,1 with pc_out 0..3.
//    Skid: valid cycles 3,4,5,6. No skid: valid cycles 3,5,7,9.
//  2 ready=0 for 6 cycles while pc_out=2 -> instr_out/pc_out stable; imem_req drops once full;
//    on release, pc 2,3,4 delivered once each with no gaps or duplicates.
//  3 redirect=1, redirect_pc=0x40 while pc_out=5 valid, ready=0
//    -> next instr_valid has pc_out=0x40; pc 5..7 never appear.
//  4 RESET_PC=0xFE, PC_W=8, ready=1 -> pc_out FE,FF,00,01; imem_addr wraps identically.
//  5 imem[3]=HALT (opcode 1F) -> pc 0..3 delivered, halted=1.
//    imem_req=0 and instr_valid=0 for 20 cycles. Redirect to 0 resumes at pc 0 with halted=0.
//  6 rst_n=0 for one edge with buffer full and a read inflight -> next cycle all outputs 0.
//    First delivered pc_out=RESET_PC; the stale inflight word is never delivered.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, synchronous imem fetch, {pc, instr} buffer with valid/ready output.
// Define IFU_SKID_BUF_EN for a 2-entry buffer (1 instr/cycle); otherwise the buffer holds 1 entry.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [4:0]         opcode_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

`ifdef IFU_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [4:0] OP_HALT = 5'h1F;

    // Handshake: an entry transfers on any rising edge where instr_valid and instr_ready are both
    // high; while instr_valid is high and instr_ready low, instr_out/opcode_out/pc_out hold.

    logic [1:0]         state;
    logic [PC_W-1:0]    pc_q;
    logic               inflight_q;
    logic [PC_W-1:0]    tag_q;
    logic [CNT_W-1:0]   count_q;
    logic [PC_W-1:0]    pc_buf [DEPTH];
    logic [INSTR_W-1:0] ins_buf[DEPTH];
    logic [PC_W-1:0]    pc_nxt [DEPTH];
    logic [INSTR_W-1:0] ins_nxt[DEPTH];

    logic             pop;
    logic             push;
    logic             halt_cap;
    logic             issue;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] wr_idx;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight_q & ~redirect;
    assign halt_cap    = push & (imem_rdata[INSTR_W-1 -: 5] == OP_HALT);
    // Occupancy the buffer will reach once the current pop and in-flight read settle.
    assign occ         = count_q - CNT_W'(pop) + CNT_W'(inflight_q);
    assign issue       = (state == S_RUN) & ~redirect & ~halt_cap & (occ < CNT_W'(DEPTH));
    assign wr_idx      = count_q - CNT_W'(pop);

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign instr_out  = ins_buf[0];
    assign opcode_out = ins_buf[0][INSTR_W-1 -: 5];
    assign pc_out     = pc_buf[0];
    assign halted     = (state == S_HALT);

    // Head-at-index-0 shift buffer: pop shifts down, push lands just above the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pc_nxt[i]  = pc_buf[i];
            ins_nxt[i] = ins_buf[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                pc_nxt[i]  = pc_buf[i+1];
                ins_nxt[i] = ins_buf[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    pc_nxt[i]  = tag_q;
                    ins_nxt[i] = imem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf[i]  <= '0;
                ins_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf[i]  <= pc_nxt[i];
                ins_buf[i] <= ins_nxt[i];
            end
            if (redirect) begin
                // Head may still transfer this cycle; everything behind it and in flight is dropped.
                state      <= S_RUN;
                pc_q       <= redirect_pc;
                inflight_q <= 1'b0;
                count_q    <= '0;
            end else begin
                count_q    <= count_q - CNT_W'(pop) + CNT_W'(push);
                inflight_q <= issue;
                if (issue) begin
                    pc_q  <= pc_q + PC_W'(1);
                    tag_q <= pc_q;
                end
                case (state)
                    S_IDLE:  state <= S_RUN;
                    S_RUN:   if (halt_cap) state <= S_HALT;
                    S_HALT:  state <= S_HALT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
